// File: rtl/mem_port_arb_if.sv
// mem_port_arb_if: two ap_memory requester ports plus the shared RAM port
interface mem_port_arb_if #(
  parameter int ADDR_BITS = 6,
  parameter int DATA_BITS = 32
);
  logic [ADDR_BITS-1:0] req0_address0, req1_address0, mem_address0;
  logic                 req0_ce0, req1_ce0, req0_we0, req1_we0;
  logic [DATA_BITS-1:0] req0_d0, req1_d0, req0_q0, req1_q0;
  logic                 req0_gnt, req1_gnt, req0_q_vld, req1_q_vld;
  logic                 mem_ce0, mem_we0;
  logic [DATA_BITS-1:0] mem_d0, mem_q0;
  modport slave (
    input  req0_address0, req0_ce0, req0_we0, req0_d0,
    input  req1_address0, req1_ce0, req1_we0, req1_d0,
    output req0_gnt, req0_q0, req0_q_vld,
    output req1_gnt, req1_q0, req1_q_vld,
    output mem_address0, mem_ce0, mem_we0, mem_d0,
    input  mem_q0
  );
  modport master (
    output req0_address0, req0_ce0, req0_we0, req0_d0,
    output req1_address0, req1_ce0, req1_we0, req1_d0,
    input  req0_gnt, req0_q0, req0_q_vld,
    input  req1_gnt, req1_q0, req1_q_vld,
    input  mem_address0, mem_ce0, mem_we0, mem_d0,
    output mem_q0
  );
endinterface

// File: rtl/mem_port_arb.sv
// mem_port_arb: round-robin, burst-limited sharing of one 1-cycle-latency RAM port
module mem_port_arb #(
  parameter int ADDR_BITS = 6,
  parameter int DATA_BITS = 32,
  parameter int BURST_MAX = 4
) (
  input logic           ap_clk,
  input logic           ap_rst,
  mem_port_arb_if.slave bus
);
  localparam logic [3:0] BMAX = 4'(BURST_MAX);
  logic                 last_owner, granted_prev, rd_pend, rd_tag;
  logic [3:0]           streak;
  logic [DATA_BITS-1:0] hold_0, hold_1;
  logic                 sel, any, keep, we_sel;
  logic [ADDR_BITS-1:0] addr_sel;
  // grant selection: the previous owner keeps a tie only while its burst is unexhausted
  always_comb begin
    keep     = granted_prev && (streak < BMAX);
    sel      = (bus.req0_ce0 && bus.req1_ce0) ? (keep ? last_owner : ~last_owner) : bus.req1_ce0;
    any      = (bus.req0_ce0 || bus.req1_ce0) && !ap_rst;
    we_sel   = sel ? bus.req1_we0 : bus.req0_we0;
    addr_sel = sel ? bus.req1_address0 : bus.req0_address0;
  end
  assign bus.req0_gnt     = any && !sel;
  assign bus.req1_gnt     = any && sel;
  assign bus.mem_ce0      = any;
  assign bus.mem_we0      = any && we_sel;
  assign bus.mem_address0 = addr_sel;
  assign bus.mem_d0       = sel ? bus.req1_d0 : bus.req0_d0;
  assign bus.req0_q_vld   = rd_pend && !rd_tag;
  assign bus.req1_q_vld   = rd_pend && rd_tag;
  assign bus.req0_q0      = bus.req0_q_vld ? bus.mem_q0 : hold_0;
  assign bus.req1_q0      = bus.req1_q_vld ? bus.mem_q0 : hold_1;
  // arbitration history, read-return tag and per-requester read-data holding registers
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      last_owner   <= 1'b1;
      granted_prev <= 1'b0;
      streak       <= '0;
      rd_pend      <= 1'b0;
      rd_tag       <= 1'b0;
      hold_0       <= '0;
      hold_1       <= '0;
    end else begin
      granted_prev <= any;
      rd_pend      <= any && !we_sel;
      rd_tag       <= sel;
      last_owner   <= any ? sel : last_owner;
      streak       <= !any ? streak :
                      (!granted_prev || sel != last_owner) ? 4'd1 :
                      (streak == BMAX) ? streak : streak + 4'd1;
      hold_0       <= bus.req0_q_vld ? bus.mem_q0 : hold_0;
      hold_1       <= bus.req1_q_vld ? bus.mem_q0 : hold_1;
    end
  end
endmodule

// File: tb/tb_mem_port_arb.sv
// tb_mem_port_arb: table-driven arbitration vectors plus hand-written read/reset sequences
module tb_mem_port_arb;
  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  int   n_chk  = 0;
  int   n_fail = 0;
  always #5 ap_clk = ~ap_clk;

  mem_port_arb_if #(.ADDR_BITS(6), .DATA_BITS(32)) bus ();
  mem_port_arb_if #(.ADDR_BITS(6), .DATA_BITS(32)) bus_b ();

  mem_port_arb #(.ADDR_BITS(6), .DATA_BITS(32), .BURST_MAX(4)) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus.slave));
  mem_port_arb #(.ADDR_BITS(6), .DATA_BITS(32), .BURST_MAX(1)) dut_b (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus_b.slave));

  assign bus_b.req0_address0 = bus.req0_address0;
  assign bus_b.req0_ce0      = bus.req0_ce0;
  assign bus_b.req0_we0      = bus.req0_we0;
  assign bus_b.req0_d0       = bus.req0_d0;
  assign bus_b.req1_address0 = bus.req1_address0;
  assign bus_b.req1_ce0      = bus.req1_ce0;
  assign bus_b.req1_we0      = bus.req1_we0;
  assign bus_b.req1_d0       = bus.req1_d0;
  assign bus_b.mem_q0        = '0;

  // behavioural single-port RAM with 1-cycle read latency
  logic [31:0] ram [64];
  logic [31:0] ram_q = '0;
  always @(posedge ap_clk) begin
    if (bus.mem_ce0) begin
      if (bus.mem_we0) ram[bus.mem_address0] <= bus.mem_d0;
      else ram_q <= ram[bus.mem_address0];
    end
  end
  assign bus.mem_q0 = ram_q;

  typedef struct {
    logic c0, c1;
    logic g0, g1;
    logic b0, b1;
  } vec_t;
  vec_t tbl [17];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic c0, input logic w0, input logic [5:0] a0, input logic [31:0] d0,
                       input logic c1, input logic w1, input logic [5:0] a1, input logic [31:0] d1);
    @(negedge ap_clk);
    bus.req0_ce0 = c0; bus.req0_we0 = w0; bus.req0_address0 = a0; bus.req0_d0 = d0;
    bus.req1_ce0 = c1; bus.req1_we0 = w1; bus.req1_address0 = a1; bus.req1_d0 = d1;
    #1;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    tbl[0]  = '{1, 1, 1, 0, 1, 0};
    tbl[1]  = '{1, 1, 1, 0, 0, 1};
    tbl[2]  = '{1, 1, 1, 0, 1, 0};
    tbl[3]  = '{1, 1, 1, 0, 0, 1};
    tbl[4]  = '{1, 1, 0, 1, 1, 0};
    tbl[5]  = '{1, 1, 0, 1, 0, 1};
    tbl[6]  = '{1, 1, 0, 1, 1, 0};
    tbl[7]  = '{1, 1, 0, 1, 0, 1};
    tbl[8]  = '{1, 1, 1, 0, 1, 0};
    tbl[9]  = '{1, 0, 1, 0, 1, 0};
    tbl[10] = '{1, 0, 1, 0, 1, 0};
    tbl[11] = '{1, 1, 1, 0, 0, 1};
    tbl[12] = '{1, 1, 0, 1, 1, 0};
    tbl[13] = '{1, 1, 0, 1, 0, 1};
    tbl[14] = '{0, 1, 0, 1, 0, 1};
    tbl[15] = '{0, 0, 0, 0, 0, 0};
    tbl[16] = '{1, 1, 1, 0, 1, 0};
    idle();
    idle();
    drive(1, 1, 5, 32'hA5A5A5A5, 0, 0, 0, 0);
    chk("rst_gnt0", bus.req0_gnt, 0);
    chk("rst_mem_ce0", bus.mem_ce0, 0);
    chk("rst_q_vld0", bus.req0_q_vld, 0);
    chk("rst_q_vld1", bus.req1_q_vld, 0);
    chk("rst_q0_0", bus.req0_q0, 0);
    chk("rst_q0_1", bus.req1_q0, 0);
    ap_rst = 1'b0;
    #1;
    chk("wr_gnt0", bus.req0_gnt, 1);
    chk("wr_gnt1", bus.req1_gnt, 0);
    chk("wr_mem_we0", bus.mem_we0, 1);
    chk("wr_mem_addr", 32'(bus.mem_address0), 5);
    chk("wr_mem_d0", bus.mem_d0, 32'hA5A5A5A5);
    idle();
    chk("wr_no_vld0", bus.req0_q_vld, 0);
    chk("wr_no_vld1", bus.req1_q_vld, 0);
    @(negedge ap_clk);
    ap_rst = 1'b1;
    @(negedge ap_clk);
    ap_rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].c0, 1, 30, 32'(i), tbl[i].c1, 1, 31, 32'(i + 100));
      chk($sformatf("tbl%0d_gnt0", i), bus.req0_gnt, tbl[i].g0);
      chk($sformatf("tbl%0d_gnt1", i), bus.req1_gnt, tbl[i].g1);
      chk($sformatf("tbl%0d_b1_gnt0", i), bus_b.req0_gnt, tbl[i].b0);
      chk($sformatf("tbl%0d_b1_gnt1", i), bus_b.req1_gnt, tbl[i].b1);
      chk($sformatf("tbl%0d_vld", i), {bus.req0_q_vld, bus.req1_q_vld}, 0);
    end
    drive(1, 1, 1, 32'h11, 0, 0, 0, 0);
    chk("pre1_gnt0", bus.req0_gnt, 1);
    drive(0, 0, 0, 0, 1, 1, 2, 32'h22);
    chk("pre2_gnt1", bus.req1_gnt, 1);
    drive(0, 0, 0, 0, 1, 1, 9, 32'h12345678);
    chk("raw_wr_gnt1", bus.req1_gnt, 1);
    chk("raw_wr_addr", 32'(bus.mem_address0), 9);
    chk("raw_wr_d0", bus.mem_d0, 32'h12345678);
    drive(1, 0, 9, 0, 0, 0, 0, 0);
    chk("raw_rd_gnt0", bus.req0_gnt, 1);
    chk("raw_rd_we", bus.mem_we0, 0);
    chk("raw_rd_vld0_early", bus.req0_q_vld, 0);
    idle();
    chk("raw_vld0", bus.req0_q_vld, 1);
    chk("raw_q0", bus.req0_q0, 32'h12345678);
    chk("raw_vld1", bus.req1_q_vld, 0);
    idle();
    chk("raw_vld0_after", bus.req0_q_vld, 0);
    chk("raw_q0_hold", bus.req0_q0, 32'h12345678);
    chk("raw_vld1_after", bus.req1_q_vld, 0);
    drive(1, 0, 1, 0, 0, 0, 0, 0);
    chk("il_gnt0", bus.req0_gnt, 1);
    drive(0, 0, 0, 0, 1, 0, 2, 0);
    chk("il_gnt1", bus.req1_gnt, 1);
    chk("il_vld0", bus.req0_q_vld, 1);
    chk("il_q0_0", bus.req0_q0, 32'h11);
    chk("il_vld1_early", bus.req1_q_vld, 0);
    idle();
    chk("il_vld1", bus.req1_q_vld, 1);
    chk("il_q0_1", bus.req1_q0, 32'h22);
    chk("il_vld0_off", bus.req0_q_vld, 0);
    chk("il_q0_0_hold", bus.req0_q0, 32'h11);
    drive(1, 0, 2, 0, 0, 0, 0, 0);
    chk("mr_gnt0", bus.req0_gnt, 1);
    @(negedge ap_clk);
    ap_rst = 1'b1;
    bus.req1_ce0 = 1'b1; bus.req1_we0 = 1'b0; bus.req1_address0 = 1;
    #1;
    chk("mr_rst_gnt0", bus.req0_gnt, 0);
    chk("mr_rst_gnt1", bus.req1_gnt, 0);
    chk("mr_rst_vld0", bus.req0_q_vld, 0);
    chk("mr_rst_q0_0", bus.req0_q0, 0);
    chk("mr_rst_q0_1", bus.req1_q0, 0);
    @(negedge ap_clk);
    ap_rst = 1'b0;
    #1;
    chk("mr_rel_vld0", bus.req0_q_vld, 0);
    chk("mr_rel_vld1", bus.req1_q_vld, 0);
    chk("mr_rel_q0_0", bus.req0_q0, 0);
    chk("mr_rel_q0_1", bus.req1_q0, 0);
    chk("mr_tie_gnt0", bus.req0_gnt, 1);
    chk("mr_tie_gnt1", bus.req1_gnt, 0);
    idle();
    chk("mr_tie_vld0", bus.req0_q_vld, 1);
    chk("mr_tie_q0", bus.req0_q0, 32'h22);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
